// File: rtl/i2c_slave_datapath.sv
// -----------------------------------------------------------------------------
// i2c_slave_datapath
//
// I2C target (slave) datapath. SCL and SDA are oversampled on i2c_clk. The
// block detects START, repeated START and STOP, matches a 7-bit address, and
// then either acknowledges write bytes or returns read bytes. It never
// stretches SCL, so i2c_clk must run at least 8x the SCL rate.
//
// Build option:
//   GENERAL_CALL_EN  when defined, address byte 8'h00 (general call, write) is
//                    acknowledged and handled as a normal write, with gen_call
//                    high until the next START or STOP. 8'h01 is not answered.
//                    When undefined, gen_call is tied low.
//
// Parameters:
//   SLAVE_ADDR   7-bit address this target answers to
//   SYNC_STAGES  synchronizer depth on SCL/SDA (2..3)
//
// Ports:
//   i2c_clk      system clock
//   reset_n      asynchronous active-low reset
//   i2c_scl_in   SCL as seen on the bus
//   i2c_sda_in   SDA as seen on the bus
//   i2c_sda_oe   1 = pull SDA low, 0 = release
//   tx_data      byte returned on reads, captured when tx_load pulses
//   tx_load      1-cycle pulse, tx_data captured into the shifter
//   rx_data      last byte received from the master
//   rx_valid     1-cycle pulse, rx_data updated
//   rw           R/W bit of the current addressed transaction (1 = read)
//   busy         high from address match until STOP, NACK-end or mismatch
//   gen_call     high during a general-call transaction
//
// States:
//   state      | meaning
//   IDLE       | bus free, nothing addressed
//   ADDR       | shifting in the address byte
//   ADDR_ACK   | driving ACK for a matched address
//   RX_DATA    | shifting in a write byte
//   RX_ACK     | driving ACK for a received byte
//   TX_DATA    | driving a read byte
//   TX_ACK     | sampling the master's ACK/NACK
//   WAIT_STOP  | not addressed or NACKed, SDA released until START/STOP
// -----------------------------------------------------------------------------
module i2c_slave_datapath #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i2c_clk,
    input  logic       reset_n,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy,
    output logic       gen_call
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX_DATA,
        RX_ACK,
        TX_DATA,
        TX_ACK,
        WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic [7:0]             shift;
    logic [2:0]             bit_cnt;
    logic                   bit_done;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] shift_in;
    logic       gc_hit;
    logic       addr_ok;

    // Synchronizers start at the idle-bus level so reset release does not
    // create spurious edges.
    always_ff @(posedge i2c_clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_prev;
    assign scl_fall = ~scl_s &  scl_prev;

    // SCL must be high in both samples, so a simultaneous SCL/SDA change is
    // never taken as START/STOP; the SCL edge is handled normally instead.
    assign start_det =  sda_prev & ~sda_s & scl_prev & scl_s;
    assign stop_det  = ~sda_prev &  sda_s & scl_prev & scl_s;

    assign shift_in = {shift[6:0], sda_s};

`ifdef GENERAL_CALL_EN
    assign gc_hit = (shift_in == 8'h00);
`else
    assign gc_hit = 1'b0;
`endif

    assign addr_ok = (shift_in[7:1] == SLAVE_ADDR) || gc_hit;

    always_ff @(posedge i2c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shift      <= 8'h00;
            bit_cnt    <= 3'd0;
            bit_done   <= 1'b0;
            i2c_sda_oe <= 1'b0;
            tx_load    <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rw         <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tx_load  <= 1'b0;
            rx_valid <= 1'b0;
            if (start_det) begin
                state      <= ADDR;
                bit_cnt    <= 3'd0;
                bit_done   <= 1'b0;
                i2c_sda_oe <= 1'b0;
                rw         <= 1'b0;
            end else if (stop_det) begin
                state      <= IDLE;
                bit_cnt    <= 3'd0;
                bit_done   <= 1'b0;
                i2c_sda_oe <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        i2c_sda_oe <= 1'b0;
                    end

                    ADDR: begin
                        // bit_done blocks further shifting while the ACK
                        // slot is pending, so the counter never wraps.
                        if (scl_rise && !bit_done) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                if (addr_ok) begin
                                    rw       <= shift_in[0];
                                    busy     <= 1'b1;
                                    bit_done <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall && bit_done) begin
                            i2c_sda_oe <= 1'b1;
                            state      <= ADDR_ACK;
                            bit_done   <= 1'b0;
                            bit_cnt    <= 3'd0;
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                shift      <= tx_data;
                                tx_load    <= 1'b1;
                                i2c_sda_oe <= ~tx_data[7];
                                state      <= TX_DATA;
                            end else begin
                                i2c_sda_oe <= 1'b0;
                                state      <= RX_DATA;
                            end
                        end
                    end

                    RX_DATA: begin
                        if (scl_rise && !bit_done) begin
                            shift <= shift_in;
                            if (bit_cnt == 3'd7) begin
                                rx_data  <= shift_in;
                                rx_valid <= 1'b1;
                                bit_done <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else if (scl_fall && bit_done) begin
                            i2c_sda_oe <= 1'b1;
                            state      <= RX_ACK;
                            bit_done   <= 1'b0;
                            bit_cnt    <= 3'd0;
                        end
                    end

                    RX_ACK: begin
                        if (scl_fall) begin
                            i2c_sda_oe <= 1'b0;
                            state      <= RX_DATA;
                            bit_cnt    <= 3'd0;
                        end
                    end

                    TX_DATA: begin
                        // bit 7 went out on the load; falls 1..7 drive bits
                        // 6..0 and the 8th fall frees SDA for the master ACK.
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                i2c_sda_oe <= 1'b0;
                                state      <= TX_ACK;
                                bit_cnt    <= 3'd0;
                            end else begin
                                shift      <= {shift[6:0], 1'b0};
                                i2c_sda_oe <= ~shift[6];
                                bit_cnt    <= bit_cnt + 3'd1;
                            end
                        end
                    end

                    TX_ACK: begin
                        if (scl_rise && !bit_done) begin
                            if (!sda_s) begin
                                bit_done <= 1'b1;
                            end else begin
                                state      <= WAIT_STOP;
                                i2c_sda_oe <= 1'b0;
                                busy       <= 1'b0;
                            end
                        end else if (scl_fall && bit_done) begin
                            shift      <= tx_data;
                            tx_load    <= 1'b1;
                            i2c_sda_oe <= ~tx_data[7];
                            bit_done   <= 1'b0;
                            bit_cnt    <= 3'd0;
                            state      <= TX_DATA;
                        end
                    end

                    WAIT_STOP: begin
                        i2c_sda_oe <= 1'b0;
                    end

                    default: begin
                        state      <= IDLE;
                        i2c_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GENERAL_CALL_EN
    always_ff @(posedge i2c_clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_call <= 1'b0;
        end else if (start_det || stop_det) begin
            gen_call <= 1'b0;
        end else if (state == ADDR && scl_rise && !bit_done &&
                     bit_cnt == 3'd7 && gc_hit) begin
            gen_call <= 1'b1;
        end
    end
`else
    assign gen_call = 1'b0;
`endif

endmodule

// File: doc/i2c_slave_datapath.md
Name: i2c_slave_datapath

Overview:
- I2C target (slave) end of the bus, complementing the team's I2C master datapath.
- Oversamples SCL/SDA on the local `i2c_clk` and detects START, repeated START and STOP.
- Matches a 7-bit address, then either receives write bytes (with ACK) or transmits read bytes (honouring master ACK/NACK).
- Sits between the bus pads (open-drain SDA) and a simple register-file/user interface.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target answers to.
- SYNC_STAGES, 2, synchronizer depth on SCL and SDA inputs (legal range 2..3).

Ports:
- i2c_clk  input  1  system clock; must be at least 8x the SCL rate.
- reset_n  input  1  asynchronous, active-low reset.
- i2c_scl_in  input  1  SCL as seen on the bus; target never stretches the clock.
- i2c_sda_in  input  1  SDA as seen on the bus.
- i2c_sda_oe  output  1  1 = pull SDA low, 0 = release; pad logic drives 0 or Z.
- tx_data  input  8  byte to return on reads; sampled when tx_load is asserted.
- tx_load  output  1  1-cycle pulse; tx_data was captured into the shifter this cycle.
- rx_data  output  8  last byte received from master.
- rx_valid  output  1  1-cycle pulse; rx_data updated this cycle.
- rw  output  1  R/W bit of the current addressed transaction (1 = read).
- busy  output  1  high from address match until STOP, NACK-end or non-matching START.
- gen_call  output  1  high during a general-call transaction (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-low): state=IDLE; all outputs 0; rx_data=8'h00; shifters and counters 0; SDA released immediately.
- Synchronizers: SCL/SDA pass through SYNC_STAGES flops, then one "previous" flop per line.
  - scl_rise/scl_fall = edges of the synchronized SCL.
  - START = SDA 1->0 while SCL is high in both the previous and current sample.
  - STOP = SDA 0->1 under the same condition.
  - SDA and SCL changing in the same sample: not a START/STOP; the SCL edge is processed normally.
- Bit order MSB first. Bits are sampled on scl_rise. SDA is changed only on scl_fall, one i2c_clk after the edge is detected.
- States: IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP.
- START (from any state, including repeated START): go to ADDR; bit_cnt=0; release SDA; clear rw/gen_call.
- STOP (from any state): go to IDLE; release SDA; busy=0.
- ADDR: shift 8 bits on scl_rise.
  - After bit 8, on match ({addr[7:1]}==SLAVE_ADDR): latch rw=addr[0]; busy=1.
  - Next scl_fall: assert sda_oe and go to ADDR_ACK.
  - On mismatch: go to WAIT_STOP with SDA untouched.
- ADDR_ACK: on the following scl_fall, exit per rw.
  - rw=0: release SDA and go to RX_DATA.
  - rw=1: load tx_data, pulse tx_load, drive bit7 (sda_oe = ~bit), go to TX_DATA.
- RX_DATA: shift on scl_rise.
  - On the 8th bit, the same cycle: rx_data=shifted byte, rx_valid pulses.
  - Next scl_fall: assert sda_oe and go to RX_ACK.
- RX_ACK: next scl_fall releases SDA and returns to RX_DATA; bit_cnt=0.
  - No byte limit. Every received byte is ACKed.
- TX_DATA: on each scl_fall, shift and drive the next bit.
  - After the 8th bit's scl_fall, release SDA and go to TX_ACK.
- TX_ACK: sample SDA on scl_rise.
  - 0 (ACK): next scl_fall loads tx_data, pulses tx_load, drives bit7, goes to TX_DATA.
  - 1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: SDA released; wait for START or STOP.
- bit_cnt is 3 bits plus a done flag; it never wraps silently.
- sda_oe is forced 0 in IDLE and WAIT_STOP.

Optional Feature:
- Macro GENERAL_CALL_EN.
- Defined: address byte 8'h00 (addr 0, write) is ACKed and handled as a normal write; gen_call=1 until STOP/START.
  - 8'h01 (general-call read) is treated as a mismatch.
- Undefined: address 0 is a mismatch; gen_call is tied 0.

Test Plan:
- Write 0x50/W then data 0xA5, STOP: target ACKs both bytes; rx_data=8'hA5; rx_valid exactly 1 pulse; busy falls after STOP.
- Read 0x50/R, tx_data=0x3C then 0xC3, master ACK then NACK: SDA bits 00111100 then 11000011; tx_load 2 pulses; WAIT_STOP after NACK; sda_oe=0.
- Address 0x51/W then data 0xFF: no ACK; sda_oe never 1; no rx_valid; busy stays 0.
- 0x50/W, data 0x12, repeated START, 0x50/R: rx_data=8'h12; rw goes 0->1; first read bit driven after the address ACK.
- reset_n low mid-TX while driving 0: sda_oe=0 immediately, asynchronously; after release, state IDLE and all outputs 0.
- With GENERAL_CALL_EN, write 0x00/W then 0x06: both ACKed; gen_call=1; rx_data=8'h06. Without the macro: no ACK; gen_call=0.
